// File: rtl/decode_stage_if.sv
// +--------------------------------------------------------------------------+
// | decode_stage_if : D-stage inputs, writeback port and E-stage outputs     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface decode_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 32,
   parameter int RF_WIDTH   = 5
);
   logic [DATA_WIDTH-1:0] instrD;
   logic [PC_WIDTH-1:0]   pcD;
   logic                  validD;
   logic [DATA_WIDTH-1:0] regDin3W;
   logic [RF_WIDTH-1:0]   regAddr3W;
   logic                  regWriteW;
   logic                  flushE;
   logic                  stallE;

   logic                  hazardD;
   logic                  validE;
   logic                  regWriteE;
   logic [1:0]            resultSelE;
   logic                  memWriteE;
   logic [1:0]            _pcSelE;
   logic [3:0]            aluCtrlE;
   logic                  aluSelE;
   logic                  branchE;
   logic [2:0]            memCtrlE;
   logic                  isMulE;
   logic [DATA_WIDTH-1:0] dout1E;
   logic [DATA_WIDTH-1:0] dout2E;
   logic [DATA_WIDTH-1:0] immExtE;
   logic [PC_WIDTH-1:0]   pcE;
   logic [RF_WIDTH-1:0]   rs1E;
   logic [RF_WIDTH-1:0]   rs2E;
   logic [RF_WIDTH-1:0]   regAddr3E;
   logic [DATA_WIDTH-1:0] a0;

   modport master (
      output instrD, pcD, validD, regDin3W, regAddr3W, regWriteW, flushE, stallE,
      input  hazardD, validE, regWriteE, resultSelE, memWriteE, _pcSelE, aluCtrlE,
             aluSelE, branchE, memCtrlE, isMulE, dout1E, dout2E, immExtE, pcE,
             rs1E, rs2E, regAddr3E, a0
   );

   modport slave (
      input  instrD, pcD, validD, regDin3W, regAddr3W, regWriteW, flushE, stallE,
      output hazardD, validE, regWriteE, resultSelE, memWriteE, _pcSelE, aluCtrlE,
             aluSelE, branchE, memCtrlE, isMulE, dout1E, dout2E, immExtE, pcE,
             rs1E, rs2E, regAddr3E, a0
   );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
// +--------------------------------------------------------------------------+
// | decode_stage : RV32IM decode, register file, load-use detect, D->E reg   |
// | Optional macro DECODE_BYPASS_EN: same-cycle writeback read-through.      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module decode_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 32,
   parameter int RF_WIDTH   = 5
) (
   input  wire           clk,
   input  wire           rst_n,
   decode_stage_if.slave bus
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [RF_WIDTH-1:0] A0_IDX = RF_WIDTH'(10);

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_t;

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic [1:0]            result_sel;
      logic                  mem_write;
      logic [1:0]            pc_sel;
      logic [3:0]            alu_ctrl;
      logic                  alu_sel;
      logic                  branch;
      logic [2:0]            mem_ctrl;
      logic                  is_mul;
      logic [DATA_WIDTH-1:0] dout1;
      logic [DATA_WIDTH-1:0] dout2;
      logic [DATA_WIDTH-1:0] imm_ext;
      logic [PC_WIDTH-1:0]   pc;
      logic [RF_WIDTH-1:0]   rs1;
      logic [RF_WIDTH-1:0]   rs2;
      logic [RF_WIDTH-1:0]   rd;
   } e_reg_t;

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [RF_WIDTH-1:0]   rs1_d;
   logic [RF_WIDTH-1:0]   rs2_d;
   logic [RF_WIDTH-1:0]   rd_d;

   logic                  reg_write_d;
   logic [1:0]            result_sel_d;
   logic                  mem_write_d;
   logic [1:0]            pc_sel_d;
   logic [3:0]            alu_ctrl_d;
   logic                  alu_sel_d;
   logic                  branch_d;
   logic [2:0]            mem_ctrl_d;
   logic                  is_mul_d;
   logic                  uses_rs2;
   imm_t                  imm_type;
   logic [31:0]           imm32;
   logic [DATA_WIDTH-1:0] imm_ext_d;

   logic [DATA_WIDTH-1:0] regs [0:(1<<RF_WIDTH)-1];
   logic [DATA_WIDTH-1:0] dout1_d;
   logic [DATA_WIDTH-1:0] dout2_d;

   logic                  hazard;
   e_reg_t                e_d;
   e_reg_t                e_q;

   assign opcode = bus.instrD[6:0];
   assign funct3 = bus.instrD[14:12];
   assign funct7 = bus.instrD[31:25];
   assign rd_d   = bus.instrD[7 +: RF_WIDTH];
   assign rs1_d  = bus.instrD[15 +: RF_WIDTH];
   assign rs2_d  = bus.instrD[20 +: RF_WIDTH];

   // resultSel: 00 ALU, 01 load data, 10 pc+4, 11 upper immediate (aluSel=0 adds pcE for auipc)
   // pcSel: 00 pc+4, 01 pc+imm (jal / branch when taken), 10 rs1+imm (jalr)
   always_comb begin
      reg_write_d  = 1'b0;
      result_sel_d = 2'b00;
      mem_write_d  = 1'b0;
      pc_sel_d     = 2'b00;
      alu_ctrl_d   = 4'b0000;
      alu_sel_d    = 1'b0;
      branch_d     = 1'b0;
      mem_ctrl_d   = 3'b000;
      is_mul_d     = 1'b0;
      uses_rs2     = 1'b0;
      imm_type     = IMM_I;
      case (opcode)
         OP_R: begin
            reg_write_d = 1'b1;
            uses_rs2    = 1'b1;
            if (funct7 == 7'b0000001) begin
               is_mul_d   = 1'b1;
               alu_ctrl_d = {1'b0, funct3};
            end else begin
               alu_ctrl_d = {funct7[5], funct3};
            end
         end
         OP_I: begin
            reg_write_d = 1'b1;
            alu_sel_d   = 1'b1;
            // bit 30 is only an opcode modifier for srai; otherwise it belongs to the immediate
            alu_ctrl_d  = {funct7[5] & (funct3 == 3'b101), funct3};
         end
         OP_LOAD: begin
            reg_write_d  = 1'b1;
            alu_sel_d    = 1'b1;
            result_sel_d = 2'b01;
            mem_ctrl_d   = funct3;
         end
         OP_STORE: begin
            mem_write_d = 1'b1;
            alu_sel_d   = 1'b1;
            mem_ctrl_d  = funct3;
            uses_rs2    = 1'b1;
            imm_type    = IMM_S;
         end
         OP_BRANCH: begin
            branch_d   = 1'b1;
            pc_sel_d   = 2'b01;
            alu_ctrl_d = 4'b1000;
            mem_ctrl_d = funct3;
            uses_rs2   = 1'b1;
            imm_type   = IMM_B;
         end
         OP_JAL: begin
            reg_write_d  = 1'b1;
            result_sel_d = 2'b10;
            pc_sel_d     = 2'b01;
            imm_type     = IMM_J;
         end
         OP_JALR: begin
            reg_write_d  = 1'b1;
            result_sel_d = 2'b10;
            pc_sel_d     = 2'b10;
            alu_sel_d    = 1'b1;
         end
         OP_LUI: begin
            reg_write_d  = 1'b1;
            result_sel_d = 2'b11;
            alu_sel_d    = 1'b1;
            imm_type     = IMM_U;
         end
         OP_AUIPC: begin
            reg_write_d  = 1'b1;
            result_sel_d = 2'b11;
            imm_type     = IMM_U;
         end
         default: ;
      endcase
   end

   always_comb begin
      imm32 = {{20{bus.instrD[31]}}, bus.instrD[31:20]};
      case (imm_type)
         IMM_S: imm32 = {{20{bus.instrD[31]}}, bus.instrD[31:25], bus.instrD[11:7]};
         IMM_B: imm32 = {{19{bus.instrD[31]}}, bus.instrD[31], bus.instrD[7],
                         bus.instrD[30:25], bus.instrD[11:8], 1'b0};
         IMM_J: imm32 = {{11{bus.instrD[31]}}, bus.instrD[31], bus.instrD[19:12],
                         bus.instrD[20], bus.instrD[30:21], 1'b0};
         IMM_U: imm32 = {bus.instrD[31:12], 12'b0};
         default: ;
      endcase
   end

   assign imm_ext_d = DATA_WIDTH'($signed(imm32));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < (1 << RF_WIDTH); i++) begin
            regs[i] <= '0;
         end
      end else if (bus.regWriteW && (bus.regAddr3W != '0)) begin
         regs[bus.regAddr3W] <= bus.regDin3W;
      end
   end

   always_comb begin
      dout1_d = (rs1_d == '0) ? '0 : regs[rs1_d];
      dout2_d = (rs2_d == '0) ? '0 : regs[rs2_d];
`ifdef DECODE_BYPASS_EN
      if (bus.regWriteW && (bus.regAddr3W != '0) && (bus.regAddr3W == rs1_d)) begin
         dout1_d = bus.regDin3W;
      end
      if (bus.regWriteW && (bus.regAddr3W != '0) && (bus.regAddr3W == rs2_d)) begin
         dout2_d = bus.regDin3W;
      end
`endif
   end

   assign hazard = bus.validD && e_q.valid && (e_q.result_sel == 2'b01) && (e_q.rd != '0) &&
                   ((rs1_d == e_q.rd) || (uses_rs2 && (rs2_d == e_q.rd)));

   // Control effects of an invalid slot are squashed so a non-instruction cannot write or redirect
   always_comb begin
      e_d            = '0;
      e_d.valid      = bus.validD;
      e_d.reg_write  = reg_write_d & bus.validD;
      e_d.result_sel = result_sel_d;
      e_d.mem_write  = mem_write_d & bus.validD;
      e_d.pc_sel     = bus.validD ? pc_sel_d : 2'b00;
      e_d.alu_ctrl   = alu_ctrl_d;
      e_d.alu_sel    = alu_sel_d;
      e_d.branch     = branch_d & bus.validD;
      e_d.mem_ctrl   = mem_ctrl_d;
      e_d.is_mul     = is_mul_d;
      e_d.dout1      = dout1_d;
      e_d.dout2      = dout2_d;
      e_d.imm_ext    = imm_ext_d;
      e_d.pc         = bus.pcD;
      e_d.rs1        = rs1_d;
      e_d.rs2        = rs2_d;
      e_d.rd         = rd_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_q <= '0;
      end else if (!bus.stallE) begin
         if (bus.flushE || hazard) begin
            e_q <= '0;
         end else begin
            e_q <= e_d;
         end
      end
   end

   assign bus.hazardD    = hazard;
   assign bus.validE     = e_q.valid;
   assign bus.regWriteE  = e_q.reg_write;
   assign bus.resultSelE = e_q.result_sel;
   assign bus.memWriteE  = e_q.mem_write;
   assign bus._pcSelE    = e_q.pc_sel;
   assign bus.aluCtrlE   = e_q.alu_ctrl;
   assign bus.aluSelE    = e_q.alu_sel;
   assign bus.branchE    = e_q.branch;
   assign bus.memCtrlE   = e_q.mem_ctrl;
   assign bus.isMulE     = e_q.is_mul;
   assign bus.dout1E     = e_q.dout1;
   assign bus.dout2E     = e_q.dout2;
   assign bus.immExtE    = e_q.imm_ext;
   assign bus.pcE        = e_q.pc;
   assign bus.rs1E       = e_q.rs1;
   assign bus.rs2E       = e_q.rs2;
   assign bus.regAddr3E  = e_q.rd;
   assign bus.a0         = regs[A0_IDX];

endmodule

`default_nettype wire
